// File: rtl/coproc_bridge_pkg.sv
// Shared constants for the HPS PIO <-> matrix coprocessor bridge: toggle bit offsets and status layout.
// Toggle offsets are measured down from the PIO MSB, so they stay valid for any PIO width.
package coproc_bridge_pkg;

  localparam int TOG_CMD_OFS = 1;
  localparam int TOG_POP_OFS = 2;
  localparam int TOG_CLR_OFS = 3;

  localparam int STATUS_W          = 8;
  localparam int STATUS_RES_VALID  = 0;
  localparam int STATUS_IFIFO_FULL = 1;
  localparam int STATUS_OVF        = 2;
  localparam int STATUS_ACK        = 3;
  localparam int STATUS_IDLE       = 4;

  typedef struct packed {
    logic cmd;
    logic pop;
    logic clr;
  } tog_t;

endpackage

// File: rtl/coproc_sync_fifo.sv
// Show-ahead synchronous FIFO; head data valid in the cycle after the push edge, zero when empty.
// Push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module coproc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/coproc_pio_bridge.sv
// Bridge from level-only HPS PIO words to a toggle command protocol with instruction/result queues.
// Command reaches cp_instr_o two edges after the PIO change; results stall via cp_result_ready_o when full.
module coproc_pio_bridge
  import coproc_bridge_pkg::*;
#(
  parameter int PIO_W       = 32,
  parameter int RES_W       = 32,
  parameter int IFIFO_DEPTH = 4,
  parameter int RFIFO_DEPTH = 4,
  localparam int INSTR_W    = PIO_W - 3
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [PIO_W-1:0]    pio_instr_i,
  output logic [RES_W-1:0]    pio_data_o,
  output logic [STATUS_W-1:0] pio_status_o,
  output logic [INSTR_W-1:0]  cp_instr_o,
  output logic                cp_instr_valid_o,
  input  logic                cp_instr_ready_i,
  input  logic [RES_W-1:0]    cp_result_i,
  input  logic                cp_result_valid_i,
  output logic                cp_result_ready_o,
  input  logic                cp_busy_i
);

  logic [PIO_W-1:0] s_q;
  logic             primed;
  logic             ovf;
  logic             ack_tog;
  tog_t             prev_tog;
  tog_t             cur_tog;
  tog_t             raw_tog;
  tog_t             ev;

  logic                             iempty, ifull, rempty, rfull;
  logic [$clog2(IFIFO_DEPTH):0]     icount;
  logic [$clog2(RFIFO_DEPTH):0]     rcount;
  logic                             cp_xfer;
  logic                             ovf_set;

  assign cur_tog.cmd = s_q[PIO_W-TOG_CMD_OFS];
  assign cur_tog.pop = s_q[PIO_W-TOG_POP_OFS];
  assign cur_tog.clr = s_q[PIO_W-TOG_CLR_OFS];
  assign raw_tog.cmd = pio_instr_i[PIO_W-TOG_CMD_OFS];
  assign raw_tog.pop = pio_instr_i[PIO_W-TOG_POP_OFS];
  assign raw_tog.clr = pio_instr_i[PIO_W-TOG_CLR_OFS];

  assign ev      = primed ? tog_t'(cur_tog ^ prev_tog) : '0;
  assign cp_xfer = cp_instr_valid_o & cp_instr_ready_i;
  assign ovf_set = ev.cmd & ifull & ~cp_xfer;

  // The baseline is taken straight from the PIO word so a value held across reset is not a command.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s_q      <= '0;
      prev_tog <= '0;
      primed   <= 1'b0;
      ovf      <= 1'b0;
      ack_tog  <= 1'b0;
    end else begin
      s_q      <= pio_instr_i;
      prev_tog <= primed ? cur_tog : raw_tog;
      primed   <= 1'b1;
      if (ev.cmd) ack_tog <= ~ack_tog;
      if (ovf_set)     ovf <= 1'b1;
      else if (ev.clr) ovf <= 1'b0;
    end
  end

  coproc_sync_fifo #(.WIDTH(INSTR_W), .DEPTH(IFIFO_DEPTH)) u_ififo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (ev.cmd),
    .push_dat (s_q[INSTR_W-1:0]),
    .pop      (cp_instr_ready_i),
    .pop_dat  (cp_instr_o),
    .full     (ifull),
    .empty    (iempty),
    .count    (icount)
  );

  assign cp_instr_valid_o  = ~iempty;
  assign cp_result_ready_o = primed & ~rfull;

  coproc_sync_fifo #(.WIDTH(RES_W), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (cp_result_valid_i & cp_result_ready_o),
    .push_dat (cp_result_i),
    .pop      (ev.pop),
    .pop_dat  (pio_data_o),
    .full     (rfull),
    .empty    (rempty),
    .count    (rcount)
  );

  // Status reads all-zero until the first edge after reset.
  always_comb begin
    pio_status_o = '0;
    if (primed) begin
      pio_status_o[STATUS_RES_VALID]  = ~rempty;
      pio_status_o[STATUS_IFIFO_FULL] = ifull;
      pio_status_o[STATUS_OVF]        = ovf;
      pio_status_o[STATUS_ACK]        = ack_tog;
      pio_status_o[STATUS_IDLE]       = (icount == '0) & (rcount == '0) & ~cp_busy_i;
    end
  end

endmodule
